// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the multi-port integer register file.
// Parametrised modules take their defaults from here so every user agrees on them.
package reg_file_pkg;

   localparam int DEF_XLEN = 64;
   localparam int DEF_NREG = 32;
   localparam int DEF_AW   = $clog2(DEF_NREG);

   typedef logic [DEF_AW-1:0]   reg_addr_t;
   typedef logic [DEF_XLEN-1:0] xlen_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Busy scoreboard: one bit per register, set by issue, cleared by a writeback.
// A same-cycle issue to a register beats its writeback, since the new producer is still in flight.
module rf_scoreboard
   import reg_file_pkg::*;
#(
   parameter int NREG = DEF_NREG,
   parameter int NW   = 2,
   localparam int AW  = $clog2(NREG)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NW-1:0]    we,
   input  logic [NW*AW-1:0] waddr,
   input  logic             set_v,
   input  logic [AW-1:0]    set_addr,
   output logic [NREG-1:0]  busy
);

   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busyNext;

   always_comb begin
      w_busyNext = r_busy;
      for (int r = 1; r < NREG; r++) begin
         for (int i = 0; i < NW; i++) begin
            if (we[i] && (waddr[i*AW +: AW] == AW'(r))) begin
               w_busyNext[r] = 1'b0;
            end
         end
         if (set_v && (set_addr == AW'(r))) begin
            w_busyNext[r] = 1'b1;
         end
      end
      w_busyNext[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busyNext;
      end
   end

   assign busy = r_busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with highest-port-wins writes, optional write-to-read
// bypass and a busy scoreboard for the issue stage's hazard logic.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int XLEN   = DEF_XLEN,
   parameter int NREG   = DEF_NREG,
   parameter int NR     = 2,
   parameter int NW     = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG)
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NW-1:0]      we,
   input  logic [NW*AW-1:0]   waddr,
   input  logic [NW*XLEN-1:0] wdata,
   input  logic [NR*AW-1:0]   raddr,
   output logic [NR*XLEN-1:0] rdata,
   output logic [NR-1:0]      rbusy,
   input  logic               set_v,
   input  logic [AW-1:0]      set_addr,
   output logic [NREG-1:0]    busy
);

   logic [XLEN-1:0] r_regs [NREG];
   logic [AW-1:0]   w_rdAddr;
   logic [XLEN-1:0] w_rdVal;
   logic            w_rdHit;

   // Ascending port order makes the highest-index writer's NBA the one that sticks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            r_regs[r] <= '0;
         end
      end else begin
         for (int i = 0; i < NW; i++) begin
            if (we[i] && (waddr[i*AW +: AW] != '0)) begin
               r_regs[waddr[i*AW +: AW]] <= wdata[i*XLEN +: XLEN];
            end
         end
      end
   end

   always_comb begin
      rdata    = '0;
      rbusy    = '0;
      w_rdAddr = '0;
      w_rdVal  = '0;
      w_rdHit  = 1'b0;
      for (int j = 0; j < NR; j++) begin
         w_rdAddr = raddr[j*AW +: AW];
         w_rdVal  = r_regs[w_rdAddr];
         w_rdHit  = 1'b0;
         if (BYPASS != 0) begin
            for (int i = 0; i < NW; i++) begin
               if (we[i] && (waddr[i*AW +: AW] == w_rdAddr)) begin
                  w_rdVal = wdata[i*XLEN +: XLEN];
                  w_rdHit = 1'b1;
               end
            end
         end
         rdata[j*XLEN +: XLEN] = (w_rdAddr == '0) ? '0 : w_rdVal;
         rbusy[j] = (w_rdAddr != '0) && busy[w_rdAddr] && !w_rdHit;
      end
   end

   rf_scoreboard #(
      .NREG (NREG),
      .NW   (NW)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we),
      .waddr    (waddr),
      .set_v    (set_v),
      .set_addr (set_addr),
      .busy     (busy)
   );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed table plus randomised reference-model stress for reg_file_mp.
// Two default-size instances (bypass on/off) share stimulus; a 4R3W instance takes the stress.
module tb_reg_file_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [1:0]   we;
   logic [9:0]   waddr;
   logic [127:0] wdata;
   logic [9:0]   raddr;
   logic         setV;
   logic [4:0]   setAddr;
   logic [127:0] rdataB1, rdataB0;
   logic [1:0]   rbusyB1, rbusyB0;
   logic [31:0]  busyB1, busyB0;

   logic [2:0]   sWe;
   logic [14:0]  sWaddr;
   logic [191:0] sWdata;
   logic [19:0]  sRaddr;
   logic         sSetV;
   logic [4:0]   sSetAddr;
   logic [255:0] sRdata;
   logic [3:0]   sRbusy;
   logic [31:0]  sBusy;

   int compared   = 0;
   int mismatched = 0;

   reg_file_mp #(.BYPASS(1)) dutB1 (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdataB1), .rbusy(rbusyB1),
      .set_v(setV), .set_addr(setAddr), .busy(busyB1)
   );

   reg_file_mp #(.BYPASS(0)) dutB0 (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdataB0), .rbusy(rbusyB0),
      .set_v(setV), .set_addr(setAddr), .busy(busyB0)
   );

   reg_file_mp #(.NR(4), .NW(3), .BYPASS(1)) dutS (
      .clk(clk), .rst_n(rst_n), .we(sWe), .waddr(sWaddr), .wdata(sWdata),
      .raddr(sRaddr), .rdata(sRdata), .rbusy(sRbusy),
      .set_v(sSetV), .set_addr(sSetAddr), .busy(sBusy)
   );

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0, wa1;
      logic [63:0] wd0, wd1;
      logic        sv;
      logic [4:0]  sa;
      logic [4:0]  ra0, ra1;
      logic [63:0] b1r0, b1r1, b0r0, b0r1;
      logic [1:0]  b1rb, b0rb;
      logic [31:0] busy;
   } vec_t;

   vec_t vecs[15];

   logic [63:0] mRegs [32];
   logic [31:0] mBusy;
   logic [63:0] expV;
   logic        expHit;
   logic [3:0]  expRb;
   logic [4:0]  mAddr;
   logic        sRst;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      we      = v.we;
      waddr   = {v.wa1, v.wa0};
      wdata   = {v.wd1, v.wd0};
      setV    = v.sv;
      setAddr = v.sa;
      raddr   = {v.ra1, v.ra0};
   endtask

   task automatic idleDefault();
      we = '0; waddr = '0; wdata = '0; setV = 1'b0; setAddr = '0; raddr = '0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // we, wa0, wa1, wd0, wd1, sv, sa, ra0, ra1, b1r0, b1r1, b0r0, b0r1, b1rb, b0rb, busy-after-edge
      vecs[0]  = '{2'b01, 5'd5,  5'd0,  64'hDEAD_BEEF, 64'h0,  1'b0, 5'd0, 5'd5, 5'd0,  64'hDEAD_BEEF, 64'h0, 64'h0, 64'h0, 2'b00, 2'b00, 32'h0};
      vecs[1]  = '{2'b00, 5'd0,  5'd0,  64'h0,  64'h0,  1'b0, 5'd0, 5'd5, 5'd5,  64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 2'b00, 2'b00, 32'h0};
      vecs[2]  = '{2'b11, 5'd7,  5'd7,  64'h1,  64'h2,  1'b0, 5'd0, 5'd7, 5'd5,  64'h2, 64'hDEAD_BEEF, 64'h0, 64'hDEAD_BEEF, 2'b00, 2'b00, 32'h0};
      vecs[3]  = '{2'b00, 5'd0,  5'd0,  64'h0,  64'h0,  1'b0, 5'd0, 5'd7, 5'd7,  64'h2, 64'h2, 64'h2, 64'h2, 2'b00, 2'b00, 32'h0};
      vecs[4]  = '{2'b01, 5'd0,  5'd0,  64'hFFFF, 64'h0, 1'b1, 5'd0, 5'd0, 5'd0,  64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 2'b00, 32'h0};
      vecs[5]  = '{2'b00, 5'd0,  5'd0,  64'h0,  64'h0,  1'b0, 5'd0, 5'd0, 5'd7,  64'h0, 64'h2, 64'h0, 64'h2, 2'b00, 2'b00, 32'h0};
      vecs[6]  = '{2'b00, 5'd0,  5'd0,  64'h0,  64'h0,  1'b1, 5'd3, 5'd3, 5'd3,  64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 2'b00, 32'h8};
      vecs[7]  = '{2'b00, 5'd0,  5'd0,  64'h0,  64'h0,  1'b0, 5'd0, 5'd3, 5'd3,  64'h0, 64'h0, 64'h0, 64'h0, 2'b11, 2'b11, 32'h8};
      vecs[8]  = '{2'b10, 5'd0,  5'd3,  64'h0,  64'h33, 1'b0, 5'd0, 5'd3, 5'd3,  64'h33, 64'h33, 64'h0, 64'h0, 2'b00, 2'b11, 32'h0};
      vecs[9]  = '{2'b00, 5'd0,  5'd0,  64'h0,  64'h0,  1'b0, 5'd0, 5'd3, 5'd5,  64'h33, 64'hDEAD_BEEF, 64'h33, 64'hDEAD_BEEF, 2'b00, 2'b00, 32'h0};
      vecs[10] = '{2'b01, 5'd3,  5'd0,  64'h44, 64'h0,  1'b1, 5'd3, 5'd3, 5'd3,  64'h44, 64'h44, 64'h33, 64'h33, 2'b00, 2'b00, 32'h8};
      vecs[11] = '{2'b00, 5'd0,  5'd0,  64'h0,  64'h0,  1'b0, 5'd0, 5'd3, 5'd7,  64'h44, 64'h2, 64'h44, 64'h2, 2'b01, 2'b01, 32'h8};
      vecs[12] = '{2'b00, 5'd0,  5'd0,  64'h0,  64'h0,  1'b1, 5'd3, 5'd3, 5'd0,  64'h44, 64'h0, 64'h44, 64'h0, 2'b01, 2'b01, 32'h8};
      vecs[13] = '{2'b11, 5'd3,  5'd12, 64'hA,  64'hC,  1'b0, 5'd0, 5'd3, 5'd12, 64'hA, 64'hC, 64'h44, 64'h0, 2'b00, 2'b01, 32'h0};
      vecs[14] = '{2'b00, 5'd0,  5'd0,  64'h0,  64'h0,  1'b0, 5'd0, 5'd3, 5'd12, 64'hA, 64'hC, 64'hA, 64'hC, 2'b00, 2'b00, 32'h0};

      idleDefault();
      sWe = '0; sWaddr = '0; sWdata = '0; sRaddr = '0; sSetV = 1'b0; sSetAddr = '0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Fill every register and mark the odd ones busy, then prove reset wipes it all.
      for (int r = 1; r < 32; r += 2) begin
         we      = 2'b11;
         waddr   = {5'(r + 1), 5'(r)};
         wdata   = {$urandom, $urandom, $urandom, $urandom};
         setV    = 1'b1;
         setAddr = 5'(r);
         @(posedge clk); #1;
      end
      idleDefault();
      checkOutput("fill.busyB1", 64'(busyB1), 64'hAAAA_AAAA);
      we = 2'b11; waddr = {5'd6, 5'd4}; wdata = {64'h1234, 64'h5678};
      setV = 1'b1; setAddr = 5'd8; rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idleDefault();
      for (int r = 0; r < 32; r++) begin
         raddr = {5'(31 - r), 5'(r)};
         #1;
         checkOutput($sformatf("reset.b1.r%0d", r), rdataB1[63:0], 64'h0);
         checkOutput($sformatf("reset.b0.r%0d", r), rdataB0[63:0], 64'h0);
         checkOutput($sformatf("reset.rbusy.r%0d", r), 64'({rbusyB1, rbusyB0}), 64'h0);
      end
      checkOutput("reset.busyB1", 64'(busyB1), 64'h0);
      checkOutput("reset.busyB0", 64'(busyB0), 64'h0);
      @(posedge clk); #1;

      for (int k = 0; k < 15; k++) begin
         applyStimulus(vecs[k]);
         #1;
         checkOutput($sformatf("row%0d.b1r0", k), rdataB1[63:0],   vecs[k].b1r0);
         checkOutput($sformatf("row%0d.b1r1", k), rdataB1[127:64], vecs[k].b1r1);
         checkOutput($sformatf("row%0d.b0r0", k), rdataB0[63:0],   vecs[k].b0r0);
         checkOutput($sformatf("row%0d.b0r1", k), rdataB0[127:64], vecs[k].b0r1);
         checkOutput($sformatf("row%0d.b1rbusy", k), 64'(rbusyB1), 64'(vecs[k].b1rb));
         checkOutput($sformatf("row%0d.b0rbusy", k), 64'(rbusyB0), 64'(vecs[k].b0rb));
         @(posedge clk); #1;
         checkOutput($sformatf("row%0d.busyB1", k), 64'(busyB1), 64'(vecs[k].busy));
         checkOutput($sformatf("row%0d.busyB0", k), 64'(busyB0), 64'(vecs[k].busy));
      end
      idleDefault();

      // Stress the 4R3W instance on a narrow address range so ports collide often.
      for (int r = 0; r < 32; r++) mRegs[r] = '0;
      mBusy = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         sRst  = (cyc == 200) || ($urandom_range(0, 39) == 0);
         rst_n = !sRst;
         sWe   = 3'($urandom_range(0, 7));
         for (int i = 0; i < 3; i++) begin
            sWaddr[i*5 +: 5]  = 5'($urandom_range(0, 7));
            sWdata[i*64 +: 64] = {$urandom, $urandom};
         end
         for (int j = 0; j < 4; j++) sRaddr[j*5 +: 5] = 5'($urandom_range(0, 7));
         sSetV    = 1'($urandom_range(0, 1));
         sSetAddr = 5'($urandom_range(0, 7));
         #1;
         expRb = '0;
         for (int j = 0; j < 4; j++) begin
            mAddr  = sRaddr[j*5 +: 5];
            expV   = mRegs[mAddr];
            expHit = 1'b0;
            for (int i = 0; i < 3; i++) begin
               if (sWe[i] && sWaddr[i*5 +: 5] == mAddr) begin
                  expV   = sWdata[i*64 +: 64];
                  expHit = 1'b1;
               end
            end
            if (mAddr == 5'd0) expV = '0;
            expRb[j] = (mAddr != 5'd0) && mBusy[mAddr] && !expHit;
            checkOutput($sformatf("stress%0d.rdata%0d", cyc, j), sRdata[j*64 +: 64], expV);
         end
         checkOutput($sformatf("stress%0d.rbusy", cyc), 64'(sRbusy), 64'(expRb));
         if (sRst) begin
            for (int r = 0; r < 32; r++) mRegs[r] = '0;
            mBusy = '0;
         end else begin
            for (int r = 1; r < 32; r++) begin
               for (int i = 0; i < 3; i++) begin
                  if (sWe[i] && sWaddr[i*5 +: 5] == 5'(r)) begin
                     mRegs[r] = sWdata[i*64 +: 64];
                     mBusy[r] = 1'b0;
                  end
               end
               if (sSetV && sSetAddr == 5'(r)) mBusy[r] = 1'b1;
            end
         end
         @(posedge clk); #1;
         checkOutput($sformatf("stress%0d.busy", cyc), 64'(sBusy), 64'(mBusy));
      end
      rst_n = 1'b1;
      sWe = '0; sSetV = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
